// File: rtl/mac_pkg.sv
// Shared definitions for the multiply-accumulate datapath: operand/product
// widths, the accumulator FSM state type, and an elaboration-time log2 helper.
package mac_pkg;

  localparam int PROD_W    = 16;
  localparam int OPERAND_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Ceiling log2 for sizing checks; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/product_accumulator_if.sv
// Handshake bundle between the product source, the accumulator, and the
// consumer of the completed sum.
interface product_accumulator_if #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 19
) ();

  logic              start;
  logic              prod_valid;
  logic              prod_ready;
  logic [PROD_W-1:0] product;
  logic              acc_valid;
  logic              acc_ready;
  logic [ACC_W-1:0]  acc_sum;
  logic              busy;
  logic [7:0]        beat_cnt;

  modport master (
    output start, prod_valid, product, acc_ready,
    input  prod_ready, acc_valid, acc_sum, busy, beat_cnt
  );

  modport slave (
    input  start, prod_valid, product, acc_ready,
    output prod_ready, acc_valid, acc_sum, busy, beat_cnt
  );

endinterface

// File: rtl/acc_beat_counter.sv
// 8-bit beat counter with synchronous clear and increment; flags the
// terminal beat (count == LEN-1) so the caller can close the run.
module acc_beat_counter #(
  parameter int LEN = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       inc,
  output logic [7:0] count,
  output logic       last
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     count <= 8'd0;
    else if (clear) count <= 8'd0;
    else if (inc)   count <= count + 8'd1;
  end

  assign last = (count == 8'(LEN - 1));

endmodule

// File: rtl/product_accumulator.sv
// Sums a fixed-length run of LEN unsigned products (one dot product) and
// offers the registered result over a valid/ready handshake.
module product_accumulator
  import mac_pkg::*;
#(
  parameter int PROD_W = mac_pkg::PROD_W,
  parameter int LEN    = 8,
  parameter int ACC_W  = 19
) (
  input logic                  clk,
  input logic                  rst_n,
  product_accumulator_if.slave bus
);

  if (LEN < 1 || LEN > 255) begin : g_len_check
    $error("product_accumulator: LEN must be in 1..255");
  end
  if (ACC_W < PROD_W + clog2(LEN)) begin : g_width_check
    $error("product_accumulator: ACC_W too narrow for LEN products");
  end

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum_q;
  logic [ACC_W-1:0] acc_next;
  logic             prod_ready;
  logic             accept;
  logic             handoff;
  logic             run_open;
  logic             last_beat;

  assign prod_ready = (state == ACCUM);
  assign accept     = bus.prod_valid & prod_ready;
  assign handoff    = (state == DONE) & bus.acc_ready;
  assign run_open   = (state == IDLE) & bus.start;
  assign acc_next   = acc + ACC_W'(bus.product);

  acc_beat_counter #(.LEN(LEN)) u_beat_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (run_open),
    .inc   (accept),
    .count (bus.beat_cnt),
    .last  (last_beat)
  );

  // NOTE: assigning a default first keeps this block free of inferred latches
  // on paths that do not change state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start)            state_nxt = ACCUM;
      ACCUM:   if (accept && last_beat)  state_nxt = DONE;
      DONE:    if (handoff)              state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // The running total restarts on each run; the presented sum is only
  // loaded on the closing beat and is left untouched after handoff.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      sum_q <= '0;
    end else begin
      if (run_open)    acc <= '0;
      else if (accept) acc <= acc_next;
      if (accept && last_beat) sum_q <= acc_next;
    end
  end

  assign bus.prod_ready = prod_ready;
  assign bus.acc_valid  = (state == DONE);
  assign bus.acc_sum    = sum_q;
  assign bus.busy       = (state != IDLE);

  a_product_stable : assert property (
    @(posedge clk) disable iff (!rst_n)
    (bus.prod_valid && !prod_ready) |=> (!bus.prod_valid || $stable(bus.product))
  );

  a_sum_stable : assert property (
    @(posedge clk) disable iff (!rst_n)
    (bus.acc_valid && !bus.acc_ready) |=> $stable(bus.acc_sum)
  );

endmodule

// File: tb/tb_product_accumulator.sv
// Self-checking bench: directed plan items plus randomized runs compared to a
// sum-of-products model; a second LEN=1 instance covers the single-beat build.
module tb_product_accumulator;

  logic clk;
  logic rst_n;

  int n_cmp;
  int n_bad;

  // Reference model: plain running sum and beat count of accepted products.
  int unsigned exp_sum;
  int unsigned exp_beats;

  product_accumulator_if #(.PROD_W(16), .ACC_W(19)) bus8 ();
  product_accumulator_if #(.PROD_W(16), .ACC_W(16)) bus1 ();

  product_accumulator #(.PROD_W(16), .LEN(8), .ACC_W(19)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  product_accumulator #(.PROD_W(16), .LEN(1), .ACC_W(16)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic open_run();
    bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    exp_sum   = 0;
    exp_beats = 0;
  endtask

  // Present one product after 'gap' idle cycles and hold it until accepted.
  task automatic send(input int unsigned p, input int gap);
    bus8.prod_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      check("ready_in_gap", 32'(bus8.prod_ready), 32'd1);
      step();
    end
    bus8.prod_valid = 1'b1;
    bus8.product    = 16'(p);
    for (int t = 0; t < 50; t++) begin
      if (bus8.prod_ready) begin
        step();
        bus8.prod_valid = 1'b0;
        exp_sum   += p;
        exp_beats += 1;
        return;
      end
      step();
    end
    bus8.prod_valid = 1'b0;
    check("accept_timeout", 32'd0, 32'd1);
  endtask

  // Expect a completed run, hold back-pressure 'stall' cycles, then hand off.
  task automatic drain(input string tag, input int stall);
    check({tag, "_valid"}, 32'(bus8.acc_valid), 32'd1);
    check({tag, "_sum"},   32'(bus8.acc_sum),   exp_sum);
    check({tag, "_beats"}, 32'(bus8.beat_cnt),  exp_beats);
    for (int s = 0; s < stall; s++) begin
      step();
      check({tag, "_hold_valid"}, 32'(bus8.acc_valid), 32'd1);
      check({tag, "_hold_sum"},   32'(bus8.acc_sum),   exp_sum);
      check({tag, "_hold_ready"}, 32'(bus8.prod_ready), 32'd0);
    end
    bus8.acc_ready = 1'b1;
    step();
    bus8.acc_ready = 1'b0;
    check({tag, "_after_valid"}, 32'(bus8.acc_valid), 32'd0);
    check({tag, "_after_busy"},  32'(bus8.busy),      32'd0);
    check({tag, "_after_sum"},   32'(bus8.acc_sum),   exp_sum);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus8.start = 1'b0; bus8.prod_valid = 1'b0; bus8.product = '0; bus8.acc_ready = 1'b0;
    bus1.start = 1'b0; bus1.prod_valid = 1'b0; bus1.product = '0; bus1.acc_ready = 1'b0;
    repeat (2) @(posedge clk);
    #4 rst_n = 1'b1;
    step();

    check("rst_prod_ready", 32'(bus8.prod_ready), 32'd0);
    check("rst_acc_valid",  32'(bus8.acc_valid),  32'd0);
    check("rst_acc_sum",    32'(bus8.acc_sum),    32'd0);
    check("rst_busy",       32'(bus8.busy),       32'd0);
    check("rst_beat_cnt",   32'(bus8.beat_cnt),   32'd0);

    // Full-scale run: 8 x 255*255, back to back.
    open_run();
    check("t1_ready_open", 32'(bus8.prod_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("t1_valid_before_last", 32'(bus8.acc_valid), 32'd0);
      send(255 * 255, 0);
    end
    check("t1_sum_const", 32'(bus8.acc_sum), 32'd520200);
    drain("t1", 0);

    // Products 1..8 with random gaps.
    open_run();
    for (int i = 1; i <= 8; i++) begin
      send(i, int'($urandom_range(0, 3)));
      if (i < 8) check("t2_beat_cnt", 32'(bus8.beat_cnt), exp_beats);
    end
    check("t2_sum_const", 32'(bus8.acc_sum), 32'd36);
    drain("t2", 0);

    // Back-pressure for 5 cycles.
    open_run();
    for (int i = 0; i < 8; i++) send($urandom_range(0, 255) * $urandom_range(0, 255), 0);
    drain("t3", 5);

    // start ignored in ACCUM and in the handoff cycle.
    open_run();
    for (int i = 0; i < 3; i++) send(100 + i, 0);
    bus8.start = 1'b1;
    step();
    bus8.start = 1'b0;
    check("t4_no_clear_cnt", 32'(bus8.beat_cnt), 32'd3);
    for (int i = 3; i < 8; i++) send(100 + i, 0);
    check("t4_sum", 32'(bus8.acc_sum), exp_sum);
    bus8.acc_ready = 1'b1;
    bus8.start     = 1'b1;
    step();
    bus8.acc_ready = 1'b0;
    bus8.start     = 1'b0;
    check("t4_idle_busy", 32'(bus8.busy), 32'd0);
    step();
    check("t4_still_idle", 32'(bus8.busy), 32'd0);
    check("t4_cnt_held",   32'(bus8.beat_cnt), 32'd8);
    check("t4_ready_low",  32'(bus8.prod_ready), 32'd0);

    // Async reset mid-run discards the partial sum.
    open_run();
    for (int i = 0; i < 4; i++) send(1000, 0);
    #3 rst_n = 1'b0;
    #1;
    check("t5_rst_acc_sum",   32'(bus8.acc_sum),    32'd0);
    check("t5_rst_beat_cnt",  32'(bus8.beat_cnt),   32'd0);
    check("t5_rst_busy",      32'(bus8.busy),       32'd0);
    check("t5_rst_ready",     32'(bus8.prod_ready), 32'd0);
    @(posedge clk);
    #4 rst_n = 1'b1;
    step();
    open_run();
    for (int i = 0; i < 8; i++) send(1, 0);
    check("t5_sum_after_rst", 32'(bus8.acc_sum), 32'd8);
    drain("t5", 0);

    // Randomized runs against the model.
    for (int r = 0; r < 6; r++) begin
      open_run();
      for (int i = 0; i < 8; i++)
        send($urandom_range(0, 255) * $urandom_range(0, 255), int'($urandom_range(0, 3)));
      drain("rand", int'($urandom_range(0, 4)));
    end

    // LEN=1 build: first accept completes the run.
    bus1.start = 1'b1;
    step();
    bus1.start      = 1'b0;
    bus1.prod_valid = 1'b1;
    bus1.product    = 16'd300;
    check("len1_ready", 32'(bus1.prod_ready), 32'd1);
    step();
    bus1.prod_valid = 1'b0;
    check("len1_valid", 32'(bus1.acc_valid), 32'd1);
    check("len1_sum",   32'(bus1.acc_sum),   32'd300);
    check("len1_beats", 32'(bus1.beat_cnt),  32'd1);
    bus1.acc_ready = 1'b1;
    step();
    bus1.acc_ready = 1'b0;
    check("len1_after_valid", 32'(bus1.acc_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream stage of the 8x8 unsigned multiplier.
- Consumes its 16-bit products one per accepted beat and sums a fixed-length run of LEN products, i.e. one dot product of two 8-bit vectors.
- Presents the registered sum to the next stage over a valid/ready handshake.
- Runs are framed by a start pulse; the block is otherwise idle and back-pressures the product source.

Parameters:
PROD_W, 16, product width; matches the multiplier output.
LEN, 8, number of products per run; legal range 1..255.
ACC_W, 19, sum width; must be >= PROD_W + clog2(LEN). Elaboration error otherwise.

Ports:
clk  input  1  single system clock; all state updates on its rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  one-cycle pulse opening a run; honoured only in IDLE.
prod_valid  input  1  product present on product.
prod_ready  output  1  block accepts product this cycle.
product  input  PROD_W  unsigned product from multiplier.
acc_valid  output  1  acc_sum holds a completed run.
acc_ready  input  1  downstream consumes acc_sum.
acc_sum  output  ACC_W  unsigned sum of LEN products.
busy  output  1  high in ACCUM or DONE.
beat_cnt  output  8  products accepted so far in the current run.

Behaviour:
- Reset (async assert, sync-free deassert): state=IDLE. prod_ready=0, acc_valid=0, acc_sum=0, busy=0, beat_cnt=0, internal accumulator=0.
- Reset mid-run discards the partial sum; no output is produced for that run.
- Accept = prod_valid & prod_ready. Handoff = acc_valid & acc_ready.
- prod_ready is registered state decode: 1 only in ACCUM. acc_valid: 1 only in DONE.
- IDLE:
  - start=1 -> ACCUM; accumulator cleared to 0; beat_cnt cleared to 0.
  - prod_valid is ignored (prod_ready=0).
- ACCUM:
  - On accept: accumulator += zero-extended product; beat_cnt += 1.
  - On accept with beat_cnt==LEN-1: acc_sum <= accumulator + product; state -> DONE. acc_valid is high the cycle after the last accept (latency 1).
  - No accept: hold everything; gaps of any length are allowed.
  - start is ignored.
- DONE:
  - acc_sum and acc_valid are held stable until handoff.
  - On handoff: -> IDLE next cycle, acc_valid=0. acc_sum retains its value (not cleared).
  - start is ignored, including in the handoff cycle; the source re-issues start in IDLE.
- LEN=1: the first accept goes straight to DONE.
- Arithmetic is unsigned, modulo-free: the ACC_W rule guarantees no overflow. Max case: 8 x 65025 = 520200 < 2^19.
- beat_cnt reads LEN in DONE and holds until the next start clears it.
- Simulation assertions:
  - product is stable while prod_valid & !prod_ready.
  - acc_sum does not change while acc_valid & !acc_ready.

Decomposition:
- Shared package mac_pkg holds:
  - PROD_W=16 and OPERAND_W=8 constants.
  - state typedef {IDLE, ACCUM, DONE}.
  - clog2 function used for the ACC_W check.
- One natural sub-module, acc_beat_counter: an 8-bit counter with clear/increment and a terminal flag at LEN-1, instantiated for beat_cnt.
- Datapath and FSM stay in product_accumulator.

Test Plan:
- Reset, start, then 8 back-to-back products of 65025 (255x255) -> acc_valid rises 1 cycle after the 8th accept; acc_sum=520200; beat_cnt=8.
- Products 1,2,...,8 with prod_valid gaps of 0-3 cycles -> acc_sum=36; prod_ready stays 1 throughout ACCUM; no extra beats counted.
- Completed run with acc_ready low for 5 cycles -> acc_sum/acc_valid stable for 5 cycles; prod_ready=0; after the handoff cycle the state is IDLE and acc_valid=0.
- start pulsed during ACCUM (beat 3) and during the DONE handoff cycle -> no clear, sum unaffected; the next run requires a fresh start in IDLE.
- rst_n pulled low mid-cycle after 4 beats of 1000 -> outputs zero immediately (async). After release, a run of 8x1 gives acc_sum=8, not 4008.
- LEN=1 build: start, single product 300 -> acc_valid next cycle with acc_sum=300.
